// File: rtl/video_fetch_if.sv
// DRAM video-port handshake between the fetch sequencer (master) and the arbiter (slave).
// The master raises video_req with video_addr; the slave answers with a one-cycle video_strobe.
interface video_fetch_if #(
  parameter int AW = 21
);
  logic          video_req;
  logic [AW-1:0] video_addr;
  logic          video_strobe;
  logic [15:0]   video_data;

  modport master (
    output video_req,
    output video_addr,
    input  video_strobe,
    input  video_data
  );

  modport slave (
    input  video_req,
    input  video_addr,
    output video_strobe,
    output video_data
  );
endinterface

// File: rtl/video_fetch_ctrl.sv
// Line fetch sequencer: pulls 16-pixel groups (4 x 16-bit words) into a shadow buffer and hands
// them to the renderer on each group boundary. Optional macro VIDEO_FETCH_UNDERRUN_EN adds underrun status.
module video_fetch_ctrl #(
  parameter int GROUPS = 16,
  parameter int AW     = 21
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cend,
  input  logic          post_cbeg,
  input  logic          mode_pixf_14,
  input  logic          fetch_start,
  input  logic [AW-1:0] base_addr,
  video_fetch_if.master vbus,
  output logic [63:0]   pic_bits,
  output logic          fetch_sync,
  output logic          fetch_active
`ifdef VIDEO_FETCH_UNDERRUN_EN
  ,
  output logic          underrun,
  output logic [7:0]    underrun_cnt
`endif
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_FULL
  } state_t;

  localparam logic [7:0] GROUPS_L = 8'(GROUPS);

  state_t        state;
  logic [AW-1:0] addr;
  logic [AW-1:0] grp_addr;
  logic [1:0]    wcnt;
  logic [7:0]    grp_left;
  logic [3:0]    pixcnt;
  logic          req;
  logic [63:0]   shadow;
  logic [63:0]   shadow_nxt;
  logic          pix_stb;
  logic          boundary;
  logic          stb_take;
  logic          grp_full;
  logic          last_grp;

  assign vbus.video_req  = req;
  assign vbus.video_addr = addr;

  always_comb begin
    pix_stb    = cend | (mode_pixf_14 & post_cbeg);
    boundary   = fetch_active & pix_stb & (pixcnt == 4'd15);
    // A restart in the boundary cycle owns the cycle, so the renderer sees no sync.
    fetch_sync = boundary & ~fetch_start & ~rst;
    stb_take   = (state == S_FETCH) & vbus.video_strobe & ~fetch_start;
    shadow_nxt = shadow;
    if (stb_take) shadow_nxt[{wcnt, 4'b0000} +: 16] = vbus.video_data;
    // The 4th word landing on the boundary itself still counts as a complete group.
    grp_full   = (state == S_FULL) | (stb_take & (wcnt == 2'd3));
    last_grp   = (grp_left <= 8'd1);
  end

  // Shadow buffer is pure data; stale content is harmless because wcnt restarts at 0.
  always_ff @(posedge clk) begin
    if (stb_take) shadow <= shadow_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_IDLE;
      req          <= 1'b0;
      addr         <= '0;
      grp_addr     <= '0;
      wcnt         <= 2'd0;
      grp_left     <= 8'd0;
      pixcnt       <= 4'd0;
      pic_bits     <= 64'd0;
      fetch_active <= 1'b0;
    end else if (fetch_start) begin
      state        <= S_FETCH;
      req          <= 1'b1;
      addr         <= base_addr;
      grp_addr     <= base_addr;
      wcnt         <= 2'd0;
      grp_left     <= GROUPS_L;
      pixcnt       <= 4'd0;
      fetch_active <= 1'b1;
    end else begin
      if (fetch_active && pix_stb) pixcnt <= pixcnt + 4'd1;

      // Request resumes one cycle after an underrun skip.
      if (state == S_FETCH && !req) req <= 1'b1;

      if (stb_take) begin
        addr <= addr + AW'(1);
        wcnt <= wcnt + 2'd1;
        if (wcnt == 2'd3) begin
          state <= S_FULL;
          req   <= 1'b0;
        end
      end

      if (boundary) begin
        grp_left <= grp_left - 8'd1;
        grp_addr <= grp_addr + AW'(4);
        wcnt     <= 2'd0;
        if (grp_full) begin
          pic_bits <= shadow_nxt;
        end else begin
          // Underrun: show black and jump past the unfinished group.
          pic_bits <= 64'd0;
          addr     <= grp_addr + AW'(4);
        end
        if (!last_grp) begin
          state <= S_FETCH;
          req   <= grp_full;
        end else begin
          state        <= S_IDLE;
          req          <= 1'b0;
          fetch_active <= 1'b0;
        end
      end
    end
  end

`ifdef VIDEO_FETCH_UNDERRUN_EN
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  logic underrun_hit;
  assign underrun_hit = boundary & ~grp_full;

  always_ff @(posedge clk) begin
    if (rst) begin
      underrun     <= 1'b0;
      underrun_cnt <= 8'd0;
    end else if (fetch_start) begin
      underrun     <= 1'b0;
      underrun_cnt <= 8'd0;
    end else if (underrun_hit) begin
      underrun     <= 1'b1;
      underrun_cnt <= sat_inc8(underrun_cnt);
    end
  end
`endif

endmodule
